// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32 sequencing controller:
// state encodings, opcodes, ALU operation codes and trap causes.
package riscv_ctrl_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_RWB    = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_LOAD   = 4'd6;
  localparam logic [3:0] S_LWB    = 4'd7;
  localparam logic [3:0] S_STORE  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // Only BEQ and BNE are resolved; every other funct3 falls through as not taken.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    logic t;
    case (f3)
      F3_BEQ:  t = z;
      F3_BNE:  t = ~z;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the sequencing controller and the
// datapath plus instruction/data memories.
interface multicycle_controller_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       tgt_write;
  logic       alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, funct3, zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write,
           pc_src, tgt_write, alu_src_b, alu_op, reg_write, mem_to_reg,
           trap, trap_cause
  );

  modport slave (
    output opcode, funct3, zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write,
           pc_src, tgt_write, alu_src_b, alu_op, reg_write, mem_to_reg,
           trap, trap_cause
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; expire_o flags the last
// permitted wait cycle while the request is still unanswered.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count stalled cycles without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CNT_ZERO;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32 datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and traps on stuck memories.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [1:0] cause_q;
  logic [1:0] cause_d;
  logic       timer_en_s;
  logic       timer_clear_s;
  logic       expire_s;

  assign timer_clear_s = (state_d != state_q);

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clear_s),
    .enable_i (timer_en_s),
    .expire_o (expire_s)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    timer_en_s     = 1'b0;
    bus.imem_req   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.tgt_write  = 1'b0;
    bus.alu_src_b  = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        timer_en_s   = ~bus.imem_ready;
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (expire_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.tgt_write = 1'b1;
        case (bus.opcode)
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        bus.alu_op = ALU_FUNCT;
        state_d    = S_RWB;
      end
      S_RWB: begin
        bus.reg_write = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        state_d       = S_FETCH;
      end
      S_ADDR: begin
        bus.alu_op    = ALU_ADD;
        bus.alu_src_b = 1'b1;
        if (bus.opcode == OP_LOAD) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_STORE;
        end
      end
      S_LOAD, S_STORE: begin
        bus.dmem_req  = 1'b1;
        bus.mem_read  = (state_q == S_LOAD);
        bus.mem_write = (state_q == S_STORE);
        bus.alu_src_b = 1'b1;
        timer_en_s    = ~bus.dmem_ready;
        if (bus.dmem_ready) begin
          state_d = (state_q == S_LOAD) ? S_LWB : S_FETCH;
        end else if (expire_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          state_d = state_q;
        end
      end
      S_LWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_op   = ALU_SUB;
        bus.pc_src   = 1'b1;
        bus.pc_write = branch_taken(bus.funct3, bus.zero);
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched trap cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign bus.trap       = (state_q == S_TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, hand-built trap
// sequences and random instruction streams checked against an instruction-level model.
module tb_multicycle_controller;

  localparam int LIM = 16;

  localparam logic [15:0] IMEM    = 16'h8000;
  localparam logic [15:0] DMEM    = 16'h4000;
  localparam logic [15:0] RD      = 16'h2000;
  localparam logic [15:0] WR      = 16'h1000;
  localparam logic [15:0] IRW     = 16'h0800;
  localparam logic [15:0] PCW     = 16'h0400;
  localparam logic [15:0] PCS     = 16'h0200;
  localparam logic [15:0] TGT     = 16'h0100;
  localparam logic [15:0] ASB     = 16'h0080;
  localparam logic [15:0] AOP_FN  = 16'h0040;
  localparam logic [15:0] AOP_SUB = 16'h0020;
  localparam logic [15:0] REGW    = 16'h0010;
  localparam logic [15:0] M2R     = 16'h0008;
  localparam logic [15:0] TRP     = 16'h0004;

  localparam logic [6:0] T_R  = 7'h33;
  localparam logic [6:0] T_LW = 7'h03;
  localparam logic [6:0] T_SW = 7'h23;
  localparam logic [6:0] T_BR = 7'h63;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        ir;
    logic        dr;
    logic [15:0] exp;
  } step_t;

  logic  clk = 1'b0;
  logic  reset;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  step_t q[$];
  step_t tbl[13];

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] got();
    return {bus.imem_req, bus.dmem_req, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.pc_write, bus.pc_src, bus.tgt_write,
            bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_to_reg,
            bus.trap, bus.trap_cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [6:0] op, input logic [2:0] f3, input logic z,
                               input logic ir, input logic dr, input logic [15:0] e);
    step_t s;
    s = '{op, f3, z, ir, dr, e};
    q.push_back(s);
  endfunction

  function automatic void push_trap(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                    input logic [1:0] cause);
    for (int k = 0; k < 4; k++) push(op, f3, z, rb(), rb(), TRP | {14'd0, cause});
  endfunction

  // Instruction-level model: fw/dw are the number of not-ready cycles before the
  // memory answers; LIM of them without an answer ends in a trap.
  function automatic void gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                    input int fw, input int dw);
    int c;
    logic [15:0] dexp;
    c = 0;
    while (c < fw && c < LIM) begin
      push(op, f3, z, 1'b0, rb(), IMEM);
      c++;
    end
    if (c == LIM) begin
      push_trap(op, f3, z, 2'b10);
      return;
    end
    push(op, f3, z, 1'b1, rb(), IMEM | IRW | PCW);
    push(op, f3, z, rb(), rb(), TGT);
    if (op == T_R) begin
      push(op, f3, z, rb(), rb(), AOP_FN);
      push(op, f3, z, rb(), rb(), REGW | AOP_FN);
    end else if (op == T_LW || op == T_SW) begin
      push(op, f3, z, rb(), rb(), ASB);
      dexp = DMEM | ASB | ((op == T_LW) ? RD : WR);
      c = 0;
      while (c < dw && c < LIM) begin
        push(op, f3, z, rb(), 1'b0, dexp);
        c++;
      end
      if (c == LIM) begin
        push_trap(op, f3, z, 2'b11);
        return;
      end
      push(op, f3, z, rb(), 1'b1, dexp);
      if (op == T_LW) push(op, f3, z, rb(), rb(), REGW | M2R);
    end else if (op == T_BR) begin
      push(op, f3, z, rb(), rb(),
           AOP_SUB | PCS | (((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) ? PCW : 16'h0000));
    end else begin
      push_trap(op, f3, z, 2'b01);
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic apply_step(input step_t s, input string tag);
    bus.opcode     = s.op;
    bus.funct3     = s.f3;
    bus.zero       = s.z;
    bus.imem_ready = s.ir;
    bus.dmem_ready = s.dr;
    @(negedge clk);
    chk(tag, got(), s.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_queue(input string tag);
    step_t s;
    int i;
    i = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      apply_step(s, $sformatf("%s[%0d]", tag, i));
      i++;
    end
  endtask

  // Ready lines held high during reset so any Mealy leak would show up.
  task automatic do_reset();
    reset          = 1'b0;
    bus.opcode     = T_R;
    bus.funct3     = 3'd0;
    bus.zero       = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", got(), 16'h0000);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outputs", got(), 16'h0000);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int fw;
    int dw;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] xop;

    tbl = '{
      '{T_R,  3'd0, 1'b0, 1'b1, 1'b0, IMEM | IRW | PCW},
      '{T_R,  3'd0, 1'b0, 1'b1, 1'b0, TGT},
      '{T_R,  3'd0, 1'b0, 1'b1, 1'b0, AOP_FN},
      '{T_R,  3'd0, 1'b0, 1'b1, 1'b0, REGW | AOP_FN},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b0, IMEM | IRW | PCW},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b0, TGT},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b0, ASB},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b0, DMEM | RD | ASB},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b0, DMEM | RD | ASB},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b0, DMEM | RD | ASB},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b1, DMEM | RD | ASB},
      '{T_LW, 3'd2, 1'b0, 1'b1, 1'b1, REGW | M2R},
      '{T_R,  3'd0, 1'b0, 1'b0, 1'b0, IMEM}
    };

    do_reset();
    for (int i = 0; i < 13; i++) apply_step(tbl[i], $sformatf("table[%0d]", i));
    // The last table row leaves FETCH stalled; the next stream continues from there.

    gen_instr(T_BR, 3'd0, 1'b1, 0, 0);
    gen_instr(T_BR, 3'd0, 1'b0, 0, 0);
    gen_instr(T_BR, 3'd1, 1'b1, 0, 0);
    gen_instr(T_BR, 3'd1, 1'b0, 0, 0);
    gen_instr(T_BR, 3'd4, 1'b1, 1, 0);
    gen_instr(T_SW, 3'd2, 1'b0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       begin op = T_R;  f3 = 3'($urandom_range(0, 7)); end
        1:       begin op = T_LW; f3 = 3'd2; end
        2:       begin op = T_SW; f3 = 3'd2; end
        3:       begin op = T_BR; f3 = 3'd0; end
        4:       begin op = T_BR; f3 = 3'd1; end
        default: begin op = T_BR; f3 = 3'($urandom_range(2, 7)); end
      endcase
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      dw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      gen_instr(op, f3, rb(), fw, dw);
    end
    run_queue("stream");

    gen_instr(T_R, 3'd0, 1'b0, LIM - 1, 0);
    gen_instr(T_LW, 3'd2, 1'b0, 0, LIM - 1);
    gen_instr(T_SW, 3'd2, 1'b0, 0, LIM - 1);
    gen_instr(T_LW, 3'd2, 1'b0, 0, LIM);
    run_queue("dmem_timeout");

    do_reset();
    gen_instr(T_R, 3'd0, 1'b0, LIM, 0);
    run_queue("imem_timeout");

    do_reset();
    gen_instr(T_SW, 3'd2, 1'b0, 2, LIM);
    run_queue("store_timeout");

    do_reset();
    gen_instr(7'h7F, 3'd0, 1'b0, 0, 0);
    run_queue("illegal");
    reset = 1'b0;
    #1;
    chk("async_reset_in_trap", got(), 16'h0000);
    do_reset();

    xop = 7'bxxxxxxx;
    gen_instr(xop, 3'd0, 1'b0, 0, 0);
    run_queue("x_opcode");

    do_reset();
    gen_instr(T_R, 3'd0, 1'b0, 0, 0);
    run_queue("after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
